gate_sweep_ctrl: RTL

Self-test sequencer for a combinational gate-under-test (GUT) such as the 2-input And. On `start` it drives every input vector 0 … 2^N_IN−1 onto the GUT in ascending order. It waits a programmable settle time per vector, samples the GUT output, and compares it against a caller-supplied truth table. It sits beside the gate library as the reusable hardware checker, so gate tests report pass/fail and the first failing vector instead of printing raw outputs.

---
 rtl/gate_sweep_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer: sweeps every input vector of a combinational gate,
// waits a settle time, samples its output and checks it against a truth table.
module gate_sweep_ctrl #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      fail_vec,
    output logic [2**N_IN-1:0]   result_table
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_WAIT = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam state_t     FIRST_ST  = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

    state_t               state_q, state_d;
    logic [3:0]           wait_q, wait_d;
    logic [2**N_IN-1:0]   exp_q, exp_d;
    logic [N_IN-1:0]      dut_in_q, dut_in_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [N_IN:0]        err_q, err_d;
    logic [N_IN-1:0]      fail_q, fail_d;
    logic [2**N_IN-1:0]   res_q, res_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            exp_q    <= '0;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fail_q   <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            exp_q    <= exp_d;
            dut_in_q <= dut_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
            res_q    <= res_d;
        end
    end

    // The vector register doubles as the sweep index; done/pass/busy are
    // computed one state early so they appear registered with the state.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        exp_d    = exp_q;
        dut_in_d = dut_in_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        fail_d   = fail_q;
        res_d    = res_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d  = FIRST_ST;
                    wait_d   = '0;
                    exp_d    = expected;
                    dut_in_d = '0;
                    busy_d   = 1'b1;
                    pass_d   = 1'b0;
                    err_d    = '0;
                    fail_d   = '0;
                    res_d    = '0;
                end
            end

            S_SETTLE: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    dut_in_d = '0;
                    busy_d   = 1'b0;
                end else if (wait_q == LAST_WAIT) begin
                    state_d = S_SAMPLE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end

            S_SAMPLE: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    dut_in_d = '0;
                    busy_d   = 1'b0;
                end else begin
                    res_d[dut_in_q] = dut_out;
                    if (dut_out != exp_q[dut_in_q]) begin
                        err_d = err_q + 1'b1;
                        if (err_q == '0) begin
                            fail_d = dut_in_q;
                        end
                    end
                    if (dut_in_q == '1) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d  = FIRST_ST;
                        wait_d   = '0;
                        dut_in_d = dut_in_q + 1'b1;
                    end
                end
            end

            S_DONE: begin
                state_d  = S_IDLE;
                dut_in_d = '0;
            end

            default: begin
                state_d  = S_IDLE;
                dut_in_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign dut_in       = dut_in_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_count    = err_q;
    assign fail_vec     = fail_q;
    assign result_table = res_q;

endmodule
